// File: rtl/regfile_wb_arbiter_pkg.sv
//==============================================================================
// regfile_wb_arbiter_pkg : shared core constants and requester index enum
// Rev 1.0
//==============================================================================
`default_nettype none

package regfile_wb_arbiter_pkg;

  localparam int c_DATA_WIDTH = 64;
  localparam int c_ADDR_WIDTH = 5;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LSU = 1'b1
  } req_idx_t;

endpackage : regfile_wb_arbiter_pkg

`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
//==============================================================================
// regfile_wb_arbiter : round-robin ALU/LSU write-back arbiter, one write/cycle
// Rev 1.0
//==============================================================================
`default_nettype none

module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = c_DATA_WIDTH,
  parameter int ADDR_WIDTH = c_ADDR_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic                  i_hold,
  input  logic                  i_alu_valid,
  input  logic [ADDR_WIDTH-1:0] i_alu_addr,
  input  logic [DATA_WIDTH-1:0] i_alu_data,
  input  logic                  i_lsu_valid,
  input  logic [ADDR_WIDTH-1:0] i_lsu_addr,
  input  logic [DATA_WIDTH-1:0] i_lsu_data,
  output logic                  o_alu_ready,
  output logic                  o_lsu_ready,
  output logic                  o_write_en,
  output logic [ADDR_WIDTH-1:0] o_write_addr,
  output logic [DATA_WIDTH-1:0] o_write_data,
  output logic                  o_busy
);

  req_idx_t              r_prio;
  logic                  r_write_en;
  logic [ADDR_WIDTH-1:0] r_write_addr;
  logic [DATA_WIDTH-1:0] r_write_data;

  logic                  w_enable;
  logic                  w_alu_grant;
  logic                  w_lsu_grant;
  logic                  w_accept;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_data;

  // r_prio names the requester that wins a tie; a lone valid always wins.
  assign w_enable    = ~i_hold & ~i_arst;
  assign w_alu_grant = w_enable & i_alu_valid & (~i_lsu_valid | (r_prio == REQ_ALU));
  assign w_lsu_grant = w_enable & i_lsu_valid & (~i_alu_valid | (r_prio == REQ_LSU));
  assign w_accept    = w_alu_grant | w_lsu_grant;

  assign w_sel_addr  = w_lsu_grant ? i_lsu_addr : i_alu_addr;
  assign w_sel_data  = w_lsu_grant ? i_lsu_data : i_alu_data;

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_prio <= REQ_LSU;
    end else if (w_alu_grant) begin
      r_prio <= REQ_LSU;
    end else if (w_lsu_grant) begin
      r_prio <= REQ_ALU;
    end
  end

  // x0 writes are consumed normally but never reach the register file.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_write_en   <= 1'b0;
      r_write_addr <= '0;
      r_write_data <= '0;
    end else begin
      r_write_en <= w_accept & (w_sel_addr != '0);
      if (w_accept) begin
        r_write_addr <= w_sel_addr;
        r_write_data <= w_sel_data;
      end
    end
  end

  assign o_alu_ready  = w_alu_grant;
  assign o_lsu_ready  = w_lsu_grant;
  assign o_write_en   = r_write_en;
  assign o_write_addr = r_write_addr;
  assign o_write_data = r_write_data;
  assign o_busy       = i_alu_valid | i_lsu_valid | r_write_en;

endmodule : regfile_wb_arbiter

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
//==============================================================================
// tb_regfile_wb_arbiter : directed + randomized checks against a grant model
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_regfile_wb_arbiter;

  logic        clk;
  logic        arst;
  logic        hold;
  logic        alu_v, lsu_v;
  logic [4:0]  alu_a, lsu_a;
  logic [63:0] alu_d, lsu_d;
  logic        alu_rdy, lsu_rdy, we, busy;
  logic [4:0]  waddr;
  logic [63:0] wdata;

  int checks   = 0;
  int failures = 0;

  // Reference state: who was granted last (0=ALU, 1=LSU) and expected write port.
  int          m_last;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [63:0] m_data;
  int          last_grant;

  regfile_wb_arbiter dut (
    .i_clk        (clk),
    .i_arst       (arst),
    .i_hold       (hold),
    .i_alu_valid  (alu_v),
    .i_alu_addr   (alu_a),
    .i_alu_data   (alu_d),
    .i_lsu_valid  (lsu_v),
    .i_lsu_addr   (lsu_a),
    .i_lsu_data   (lsu_d),
    .o_alu_ready  (alu_rdy),
    .o_lsu_ready  (lsu_rdy),
    .o_write_en   (we),
    .o_write_addr (waddr),
    .o_write_data (wdata),
    .o_busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Grant rule: nothing under hold; lone requester wins; tie goes to the one
  // not granted most recently.
  function automatic int model_grant(input bit h, input bit av, input bit lv, input int last);
    if (h)             return -1;
    if (av && lv)      return (last == 0) ? 1 : 0;
    if (av)            return 0;
    if (lv)            return 1;
    return -1;
  endfunction

  task automatic model_reset();
    m_last = 0;
    m_we   = 1'b0;
    m_addr = '0;
    m_data = '0;
  endtask

  // One clock cycle with the current request inputs.
  task automatic step(input string tag, input bit h);
    int g;
    hold = h;
    #2;
    g = model_grant(h, alu_v, lsu_v, m_last);
    chk({tag, ".alu_ready"}, {63'd0, alu_rdy}, {63'd0, g == 0});
    chk({tag, ".lsu_ready"}, {63'd0, lsu_rdy}, {63'd0, g == 1});
    chk({tag, ".busy"},      {63'd0, busy},    {63'd0, alu_v | lsu_v | m_we});
    @(posedge clk);
    #1;
    if (g >= 0) begin
      m_addr = (g == 0) ? alu_a : lsu_a;
      m_data = (g == 0) ? alu_d : lsu_d;
      m_we   = (m_addr != 0);
      m_last = g;
    end else begin
      m_we = 1'b0;
    end
    last_grant = g;
    chk({tag, ".write_en"},   {63'd0, we},   {63'd0, m_we});
    chk({tag, ".write_addr"}, {59'd0, waddr}, {59'd0, m_addr});
    chk({tag, ".write_data"}, wdata,          m_data);
  endtask

  initial begin
    arst  = 1'b1;
    hold  = 1'b0;
    alu_v = 1'b0; alu_a = '0; alu_d = '0;
    lsu_v = 1'b0; lsu_a = '0; lsu_d = '0;
    model_reset();
    last_grant = -1;

    // Reset state, readys held low under reset even with valids present
    #2;
    alu_v = 1'b1; lsu_v = 1'b1;
    #1;
    chk("rst.alu_ready", {63'd0, alu_rdy}, 64'd0);
    chk("rst.lsu_ready", {63'd0, lsu_rdy}, 64'd0);
    chk("rst.write_en",  {63'd0, we},      64'd0);
    chk("rst.write_addr", {59'd0, waddr},  64'd0);
    chk("rst.write_data", wdata,           64'd0);
    alu_v = 1'b0; lsu_v = 1'b0;
    @(posedge clk);
    #1;
    arst = 1'b0;

    // Single ALU requester
    alu_v = 1'b1; alu_a = 5'd7; alu_d = 64'hDEAD_BEEF;
    step("single", 1'b0);
    chk("single.addr7", {59'd0, waddr}, 64'd7);
    chk("single.data",  wdata, 64'hDEAD_BEEF);
    alu_v = 1'b0;

    // Contention: LSU, ALU, LSU, ALU
    alu_v = 1'b1; alu_a = 5'd1; alu_d = 64'h11;
    lsu_v = 1'b1; lsu_a = 5'd2; lsu_d = 64'h22;
    for (int i = 0; i < 4; i++) begin
      step("contend", 1'b0);
      chk("contend.addr_seq", {59'd0, waddr}, (i % 2 == 0) ? 64'd2 : 64'd1);
    end
    alu_v = 1'b0; lsu_v = 1'b0;

    // x0 write consumed without write enable, then ALU-only still granted
    lsu_v = 1'b1; lsu_a = 5'd0; lsu_d = 64'hFFFF;
    step("x0", 1'b0);
    chk("x0.we_low", {63'd0, we}, 64'd0);
    lsu_v = 1'b0;
    alu_v = 1'b1; alu_a = 5'd3; alu_d = 64'h33;
    step("after_x0", 1'b0);
    alu_v = 1'b0;

    // Hold with both valid: no grants, priority unchanged
    alu_v = 1'b1; alu_a = 5'd4; alu_d = 64'h44;
    lsu_v = 1'b1; lsu_a = 5'd5; lsu_d = 64'h55;
    for (int i = 0; i < 3; i++) step("hold", 1'b1);
    step("hold_release", 1'b0);
    chk("hold_release.first_is_lsu", {59'd0, waddr}, 64'd5);
    alu_v = 1'b0; lsu_v = 1'b0;

    // Idle after write to x9
    alu_v = 1'b1; alu_a = 5'd9; alu_d = 64'h99;
    step("idle_wr", 1'b0);
    alu_v = 1'b0;
    step("idle1", 1'b0);
    step("idle2", 1'b0);
    chk("idle.addr_kept", {59'd0, waddr}, 64'd9);
    chk("idle.busy", {63'd0, busy}, 64'd0);

    // Mid-stream reset with ALU x5 registered
    alu_v = 1'b1; alu_a = 5'd5; alu_d = 64'h5555;
    step("pre_rst", 1'b0);
    lsu_v = 1'b1; lsu_a = 5'd6; lsu_d = 64'h66;
    arst = 1'b1;
    #1;
    chk("midrst.write_en",  {63'd0, we},      64'd0);
    chk("midrst.alu_ready", {63'd0, alu_rdy}, 64'd0);
    chk("midrst.lsu_ready", {63'd0, lsu_rdy}, 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    arst = 1'b0;
    alu_v = 1'b0; lsu_v = 1'b0;
    step("post_rst_idle", 1'b0);
    alu_v = 1'b1; lsu_v = 1'b1;
    step("post_rst_prio", 1'b0);
    chk("post_rst_prio.lsu_first", {59'd0, waddr}, 64'd6);
    alu_v = 1'b0; lsu_v = 1'b0;

    // Randomized traffic; requesters hold their request until accepted
    for (int n = 0; n < 400; n++) begin
      if (!alu_v && ($urandom_range(0, 1) == 1)) begin
        alu_v = 1'b1;
        alu_a = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        alu_d = {$urandom, $urandom};
      end
      if (!lsu_v && ($urandom_range(0, 1) == 1)) begin
        lsu_v = 1'b1;
        lsu_a = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        lsu_d = {$urandom, $urandom};
      end
      step("rand", $urandom_range(0, 7) == 0);
      if (last_grant == 0) alu_v = 1'b0;
      if (last_grant == 1) lsu_v = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_regfile_wb_arbiter

`default_nettype wire

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, width of write-back data.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, register address width.
REQ-003 SHALL have port i_clk  input  1  clock, all state updates on rising edge.
REQ-004 SHALL have port i_arst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_hold  input  1  freeze: no grants while high.
REQ-006 SHALL have ports i_alu_valid / i_lsu_valid  input  1 each  requester has a write-back pending.
REQ-007 SHALL have ports i_alu_addr / i_lsu_addr  input  ADDR_WIDTH each  destination register.
REQ-008 SHALL have ports i_alu_data / i_lsu_data  input  DATA_WIDTH each  result value.
REQ-009 SHALL have ports o_alu_ready / o_lsu_ready  output  1 each  request accepted this cycle.
REQ-010 SHALL have port o_write_en  output  1  register file write enable.
REQ-011 SHALL have port o_write_addr  output  ADDR_WIDTH  register file write address.
REQ-012 SHALL have port o_write_data  output  DATA_WIDTH  register file write data.
REQ-013 SHALL have port o_busy  output  1  any valid pending or write issuing this cycle.

Function
REQ-014 SHALL accept a request when valid and ready are both high in the same cycle; ready SHALL be combinational from valids, i_hold and the priority pointer.
REQ-015 SHALL assert at most one ready per cycle.
REQ-016 SHALL drive both readys low while i_hold is high, regardless of valids.
REQ-017 SHALL grant the sole valid requester when only one is valid.
REQ-018 SHALL resolve simultaneous valids round-robin: grant the requester not granted most recently; after reset the LSU SHALL have priority.
REQ-019 SHALL update the round-robin pointer only on an accepted request, never on idle or held cycles.
REQ-020 SHALL register the accepted request: o_write_en, o_write_addr, o_write_data reflect it exactly one cycle after acceptance (latency 1).
REQ-021 SHALL deassert o_write_en in any cycle following a cycle with no acceptance; o_write_addr/o_write_data SHALL hold their last values.
REQ-022 SHALL accept writes addressed to register 0 (ready asserted, pointer updated) but SHALL keep o_write_en low for them.
REQ-023 SHALL sustain one accepted write per cycle back-to-back; alternating ALU/LSU under continuous dual valids.
REQ-024 SHALL leave a requester's valid/addr/data unmodelled after non-acceptance; requesters hold them until ready (no internal buffering).
REQ-025 SHALL drive o_busy = i_alu_valid | i_lsu_valid | o_write_en.

Reset
REQ-026 SHALL on i_arst asynchronously clear o_write_en, o_write_addr, o_write_data to zero and set pointer to LSU-priority.
REQ-027 SHALL, if reset asserts mid-operation, discard the registered pending write (no write-enable after release) and require requesters to re-present.
REQ-028 SHALL drive readys low while i_arst is high.

Structure
REQ-029 SHALL take DATA_WIDTH/ADDR_WIDTH defaults and a requester-index enum (REQ_ALU, REQ_LSU) from the shared core package.
REQ-030 SHALL be a single module with no sub-modules; output feeds the register file write port directly.

Verification
REQ-031 Reset: assert i_arst mid-stream with ALU write to x5 registered -> o_write_en 0 immediately, no write after release, pointer LSU-priority.
REQ-032 Single requester: ALU valid, addr 7, data 0xDEAD_BEEF -> o_alu_ready same cycle; next cycle o_write_en 1, addr 7, data 0xDEAD_BEEF.
REQ-033 Contention: both valid for 4 cycles (ALU x1=0x11, LSU x2=0x22) -> grants LSU, ALU, LSU, ALU; write port shows x2, x1, x2, x1 on successive cycles.
REQ-034 x0 write: LSU valid addr 0 data 0xFFFF -> o_lsu_ready 1, next cycle o_write_en 0; a following ALU-only cycle still grants ALU.
REQ-035 Hold: both valid, i_hold high 3 cycles -> no readys, o_write_en 0, pointer unchanged; on release first grant is the one due before hold.
REQ-036 Idle: no valids for 2 cycles after a write to x9 -> o_write_en 0, o_write_addr stays 9, o_busy 0.
